// File: rtl/stopwatch_pkg.sv
// Purpose: shared stopwatch mode type and encodings for control, datapath and display.
// Latency: none (types and constants only).
// Backpressure: none.
package stopwatch_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RUN     = 2'd0;
  localparam mode_t MODE_PAUSED  = 2'd1;
  localparam mode_t MODE_ADJ_MIN = 2'd2;
  localparam mode_t MODE_ADJ_SEC = 2'd3;

endpackage

// File: rtl/stopwatch_ctrl_debouncer.sv
// Purpose: 2-flop synchronizer, counting debouncer and rising-edge event for one raw button.
// Latency: 2 sync cycles + DB_CYCLES stable samples before the press event pulses.
// Backpressure: none; the event is a single-cycle pulse that is not held.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   btn  - raw, bouncy, asynchronous button input
//   rise - one-cycle pulse when the accepted level goes 0 -> 1
module debouncer #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  // The counter only needs to reach DB_CYCLES-1; the last mismatch accepts.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;
  logic          accept;

  assign accept = (sync[1] != level) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      // Registered edge: pulses in the same cycle the accepted level becomes 1.
      rise <= accept && sync[1];
      if (sync[1] != level) begin
        if (accept) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Any sample matching the accepted level restarts the stability count.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Purpose: stopwatch control FSM: debounced buttons, 1 Hz / 2 Hz ticks, inc/clear pulses, blink.
// Latency: pulse outputs are registered, one cycle after the tick or clear event.
// Backpressure: none; the datapath must accept every one-cycle pulse.
//
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   btn_pause, btn_clr - raw bouncy buttons
//   sw_sel            - 0 adjusts minutes, 1 adjusts seconds
//   sw_adj            - 1 enters adjust mode
//   inc_sec, inc_min  - one-cycle advance pulses to the datapath
//   clr               - one-cycle datapath clear pulse
//   mode              - RUN / PAUSED / ADJ_MIN / ADJ_SEC
//   blink             - 1 Hz, 50% duty display blink
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int DB_CYCLES = 500000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  btn_pause,
  input  logic  btn_clr,
  input  logic  sw_sel,
  input  logic  sw_adj,
  output logic  inc_sec,
  output logic  inc_min,
  output logic  clr,
  output mode_t mode,
  output logic  blink
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2 - 1);

  logic          pause_ev;
  logic          clr_ev;
  logic [1:0]    sel_sync;
  logic [1:0]    adj_sync;
  logic [PW-1:0] presc;
  logic          t1;
  logic          t2;
  logic          paused;

  debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_pause),
    .rise (pause_ev)
  );

  debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_clr),
    .rise (clr_ev)
  );

  // Switches are levels, so a synchronizer is enough; no debounce needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_sync <= '0;
      adj_sync <= '0;
    end else begin
      sel_sync <= {sel_sync[0], sw_sel};
      adj_sync <= {adj_sync[0], sw_adj};
    end
  end

  // t1 once per second, t2 twice per second (half period and wrap).
  assign t1 = (presc == P_LAST);
  assign t2 = t1 || (presc == P_HALF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr_ev || t1) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Pause toggles in every mode; while adjusting it only shows once sw_adj drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink  <= 1'b0;
      paused <= 1'b0;
    end else begin
      if (t2)       blink  <= ~blink;
      if (pause_ev) paused <= ~paused;
    end
  end

  always_comb begin
    mode = MODE_RUN;
    if (adj_sync[1]) begin
      mode = sel_sync[1] ? MODE_ADJ_SEC : MODE_ADJ_MIN;
    end else if (paused) begin
      mode = MODE_PAUSED;
    end
  end

  // Clear wins over any coincident tick; only one inc output per mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_sec <= 1'b0;
      inc_min <= 1'b0;
      clr     <= 1'b0;
    end else begin
      clr     <= clr_ev;
      inc_sec <= 1'b0;
      inc_min <= 1'b0;
      if (!clr_ev) begin
        case (mode)
          MODE_RUN:     inc_sec <= t1;
          MODE_ADJ_MIN: inc_min <= t2;
          MODE_ADJ_SEC: inc_sec <= t2;
          default:      ;
        endcase
      end
    end
  end

endmodule
